// File: rtl/mux_scan_pkg.sv
// Shared types and encodings for the mux_scan_register block.
// Optional parity output is enabled by MUX_SCAN_PARITY_EN.
package mux_scan_pkg;

  typedef enum logic {
    ST_STATIC = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam logic OE1_ACT = 1'b0;
  localparam logic OE2_ACT = 1'b0;
  localparam logic OE3_ACT = 1'b1;

  function automatic logic oe_active(
    input logic oe1,
    input logic oe2,
    input logic oe3
  );
    return (oe1 == OE1_ACT) &&
           (oe2 == OE2_ACT) &&
           (oe3 == OE3_ACT);
  endfunction

endpackage

// File: rtl/mux_scan_seq.sv
// Select sequencer: static/scan FSM, dwell counter and select register.
// sel_chg flags that sel_q took a new value on the previous edge.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int DWELL_W = 4,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic               CP,
  input  logic               MRn,
  input  logic [SEL_W-1:0]   S,
  input  logic               LE,
  input  logic               MODE,
  input  logic [DWELL_W-1:0] DWELL,
  output logic [SEL_W-1:0]   sel_q,
  output logic               sel_chg
);

  localparam logic [SEL_W:0]   NCH_V = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH - 1);

  state_e               state_q, state_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [SEL_W-1:0]     sel_d;
  logic                 chg_q, chg_d;
  logic                 load;

  assign load    = !LE && ({1'b0, S} < NCH_V);
  assign sel_chg = chg_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dwell_d = dwell_q;
    unique case (state_q)
      ST_STATIC: begin
        dwell_d = '0;
        if (MODE == MODE_SCAN)
          state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (MODE == MODE_STATIC) begin
          state_d = ST_STATIC;
          dwell_d = '0;
        end else if (dwell_q >= DWELL) begin
          sel_d   = (sel_q == LAST) ? '0 : sel_q + 1'b1;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
    endcase
    // an explicit load always wins and restarts the dwell
    if (load) begin
      sel_d   = S;
      dwell_d = '0;
    end
    chg_d = (sel_d != sel_q);
  end

  always_ff @(posedge CP or negedge MRn) begin
    if (!MRn) begin
      state_q <= ST_STATIC;
      dwell_q <= '0;
      sel_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      sel_q   <= sel_d;
      chg_q   <= chg_d;
    end
  end

endmodule

// File: rtl/mux_scan_register.sv
// N-channel registered mux with auto-scan and 3-state Y/Yn outputs.
// Define MUX_SCAN_PARITY_EN to add the registered, 3-stated PAR output.
module mux_scan_register
  import mux_scan_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int DATA_W  = 1,
  parameter int DWELL_W = 4,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   CP,
  input  logic                   MRn,
  input  logic [N_CH*DATA_W-1:0] D,
  input  logic [SEL_W-1:0]       S,
  input  logic                   LE,
  input  logic                   MODE,
  input  logic [DWELL_W-1:0]     DWELL,
  input  logic                   OE1,
  input  logic                   OE2,
  input  logic                   OE3,
`ifdef MUX_SCAN_PARITY_EN
  output tri logic               PAR,
`endif
  output tri logic [DATA_W-1:0]  Y,
  output tri logic [DATA_W-1:0]  Yn,
  output logic [SEL_W-1:0]       CH,
  output logic                   VLD
);

  logic [SEL_W-1:0]  sel_q;
  logic              sel_chg;
  logic [DATA_W-1:0] mux_w;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  ch_q;
  logic              vld_q;
  logic              oe;

  mux_scan_seq #(
    .N_CH    (N_CH),
    .DWELL_W (DWELL_W)
  ) u_seq (
    .CP      (CP),
    .MRn     (MRn),
    .S       (S),
    .LE      (LE),
    .MODE    (MODE),
    .DWELL   (DWELL),
    .sel_q   (sel_q),
    .sel_chg (sel_chg)
  );

  assign mux_w = D[int'(sel_q)*DATA_W +: DATA_W];
  assign oe    = oe_active(OE1, OE2, OE3);

  always_ff @(posedge CP or negedge MRn) begin
    if (!MRn) begin
      data_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= mux_w;
      ch_q   <= sel_q;
      vld_q  <= sel_chg;
    end
  end

  assign Y   = oe ? data_q  : {DATA_W{1'bz}};
  assign Yn  = oe ? ~data_q : {DATA_W{1'bz}};
  assign CH  = ch_q;
  assign VLD = vld_q;

`ifdef MUX_SCAN_PARITY_EN
  logic par_q;

  always_ff @(posedge CP or negedge MRn) begin
    if (!MRn) par_q <= 1'b0;
    else      par_q <= ^mux_w;
  end

  assign PAR = oe ? par_q : 1'bz;
`endif

endmodule

// File: tb/tb_mux_scan_register.sv
// Directed bench for mux_scan_register (N_CH=8 and N_CH=6, DATA_W=4).
// Undriven 3-state outputs are pulled low so a float reads Y=0 with Yn=0.
module tb_mux_scan_register;

  logic        cp;
  logic        mrn;
  logic [31:0] d;
  logic [2:0]  s;
  logic        le;
  logic        mode;
  logic [3:0]  dwell;
  logic        oe1, oe2, oe3;
  tri   [3:0]  y_w, yn_w;
  logic [2:0]  ch;
  logic        vld;

  logic [23:0] d6;
  logic [2:0]  s6;
  logic        le6;
  logic        mode6;
  tri   [3:0]  y6, yn6;
  logic [2:0]  ch6;
  logic        vld6;

  int n_chk;
  int n_fail;

  pulldown (y_w);
  pulldown (yn_w);
  pulldown (y6);
  pulldown (yn6);

`ifdef MUX_SCAN_PARITY_EN
  tri par_w, par6;
  pulldown (par_w);
  pulldown (par6);
`endif

  mux_scan_register #(
    .N_CH(8), .DATA_W(4), .DWELL_W(4)
  ) u_dut (
    .CP(cp), .MRn(mrn), .D(d), .S(s), .LE(le),
    .MODE(mode), .DWELL(dwell),
    .OE1(oe1), .OE2(oe2), .OE3(oe3),
`ifdef MUX_SCAN_PARITY_EN
    .PAR(par_w),
`endif
    .Y(y_w), .Yn(yn_w), .CH(ch), .VLD(vld)
  );

  mux_scan_register #(
    .N_CH(6), .DATA_W(4), .DWELL_W(4)
  ) u_dut6 (
    .CP(cp), .MRn(mrn), .D(d6), .S(s6), .LE(le6),
    .MODE(mode6), .DWELL(dwell),
    .OE1(oe1), .OE2(oe2), .OE3(oe3),
`ifdef MUX_SCAN_PARITY_EN
    .PAR(par6),
`endif
    .Y(y6), .Yn(yn6), .CH(ch6), .VLD(vld6)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge cp);
    #1;
  endtask

  logic [2:0] ch_exp [1:16];
  logic       vld_exp[1:16];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    ch_exp = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7,
               3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1,
               3'd3, 3'd3, 3'd3, 3'd4};
    vld_exp = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0,
                1, 0, 0, 1};
    mrn = 1'b0; le = 1'b1; mode = 1'b0; s = '0;
    dwell = '0; oe1 = 1'b0; oe2 = 1'b0; oe3 = 1'b1;
    s6 = '0; le6 = 1'b1; mode6 = 1'b0;
    for (int i = 0; i < 8; i++) d[i*4 +: 4] = 4'(i + 5);
    for (int i = 0; i < 6; i++) d6[i*4 +: 4] = 4'(i + 1);

    step();
    step();
    chk("rst_y", y_w, 4'h0);
    chk("rst_yn", yn_w, 4'hF);
    chk("rst_ch", ch, 3'd0);
    chk("rst_vld", vld, 1'b0);
    #2 mrn = 1'b1;
    step();
    chk("post_rst_vld", vld, 1'b0);
    chk("post_rst_y", y_w, 4'h5);

    // static select with one-cycle select latency
    s = 3'd5; le = 1'b0;
    step();
    le = 1'b1;
    chk("lat_ch", ch, 3'd0);
    step();
    chk("st_y", y_w, 4'hA);
    chk("st_yn", yn_w, 4'h5);
    chk("st_ch", ch, 3'd5);
    chk("st_vld", vld, 1'b1);
    s = 3'd2;
    step();
    chk("le_hi_y", y_w, 4'hA);
    chk("le_hi_ch", ch, 3'd5);
    chk("le_hi_vld", vld, 1'b0);
    s = 3'd5; le = 1'b0;
    step();
    le = 1'b1;
    step();
    chk("reload_vld", vld, 1'b0);
    d[20 +: 4] = 4'h3;
    step();
    chk("track_y", y_w, 4'h3);
    d[20 +: 4] = 4'hA;

    // scan, dwell 2, start 6, reload 3 on a step edge
    dwell = 4'd2; mode = 1'b1;
    step();
    s = 3'd6; le = 1'b0;
    step();
    le = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      if (c == 12) begin
        s = 3'd3; le = 1'b0;
      end
      step();
      le = 1'b1;
      chk($sformatf("scan_ch%0d", c), ch, ch_exp[c]);
      chk($sformatf("scan_vld%0d", c), vld, vld_exp[c]);
      chk($sformatf("scan_y%0d", c), y_w, 4'(ch_exp[c] + 5));
    end

    // six-channel instance: out-of-range loads ignored
    s6 = 3'd2; le6 = 1'b0;
    step();
    le6 = 1'b1;
    step();
    chk("n6_ch2", ch6, 3'd2);
    chk("n6_y2", y6, 4'h3);
    chk("n6_yn2", yn6, 4'hC);
    s6 = 3'd7; le6 = 1'b0;
    step();
    le6 = 1'b1;
    step();
    chk("n6_s7_ch", ch6, 3'd2);
    chk("n6_s7_vld", vld6, 1'b0);
    s6 = 3'd6; le6 = 1'b0;
    step();
    le6 = 1'b1;
    step();
    chk("n6_s6_ch", ch6, 3'd2);
    s6 = 3'd5; le6 = 1'b0;
    step();
    le6 = 1'b1;
    step();
    chk("n6_s5_ch", ch6, 3'd5);
    chk("n6_s5_y", y6, 4'h6);

    // output enable sweep on a stable static select
    mode = 1'b0;
    step();
    s = 3'd5; le = 1'b0;
    step();
    le = 1'b1;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      {oe1, oe2, oe3} = 3'(i);
      #1;
      chk($sformatf("oe%0d_y", i), y_w,
          (i == 1) ? 4'hA : 4'h0);
      chk($sformatf("oe%0d_yn", i), yn_w,
          (i == 1) ? 4'h5 : 4'h0);
      chk($sformatf("oe%0d_ch", i), ch, 3'd5);
    end
    oe1 = 1'b0; oe2 = 1'b0; oe3 = 1'b1;

`ifdef MUX_SCAN_PARITY_EN
    d[4 +: 4] = 4'b0111;
    s = 3'd1; le = 1'b0;
    step();
    le = 1'b1;
    step();
    chk("par_odd", par_w, 1'b1);
    d[4 +: 4] = 4'b0110;
    step();
    chk("par_even", par_w, 1'b0);
`endif

    // asynchronous reset in the middle of a scan
    dwell = 4'd1; mode = 1'b1;
    step();
    s = 3'd5; le = 1'b0;
    step();
    le = 1'b1;
    step();
    step();
    chk("pre_rst_ch", ch, 3'd5);
    #2 mrn = 1'b0;
    #1;
    chk("mid_rst_y", y_w, 4'h0);
    chk("mid_rst_yn", yn_w, 4'hF);
    chk("mid_rst_ch", ch, 3'd0);
    chk("mid_rst_vld", vld, 1'b0);
    step();
    mrn = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
